// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
// Groups the MEM-stage request/response signals and the data-memory req/ack
// port of mem_access_ctrl into one bundle.
//   i_mem_read / i_mem_write  load / store request from MEM control
//   i_addr / i_wdata          byte address and store data
//   o_stall                   pipeline hold
//   o_rdata / o_rdata_valid   load result and its one-cycle valid pulse
//   o_err                     one-cycle pulse, access aborted
//   o_dm_req / o_dm_we        DM request and write enable
//   o_dm_addr / o_dm_wdata    latched DM address and write data
//   i_dm_ack / i_dm_rdata     DM completion and read data
// Modport slave is the controller's view; master is the surrounding
// pipeline + memory view.
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_err;
    logic        o_dm_req;
    logic        o_dm_we;
    logic [31:0] o_dm_addr;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;

    modport slave (
        input  i_mem_read, i_mem_write, i_addr, i_wdata, i_dm_ack, i_dm_rdata,
        output o_stall, o_rdata, o_rdata_valid, o_err,
               o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata
    );

    modport master (
        output i_mem_read, i_mem_write, i_addr, i_wdata, i_dm_ack, i_dm_rdata,
        input  o_stall, o_rdata, o_rdata_valid, o_err,
               o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences MEM-stage loads/stores against a variable-latency DM req/ack
// port. Stalls the pipeline until the access finishes, returns load data,
// aborts misaligned or timed-out accesses and counts stall cycles.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   bus          mem_access_ctrl_if.slave (MEM-side and DM-side signals)
//   o_stall_cnt  saturating count of cycles with o_stall=1
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; stalls combinationally when one appears
//   REQ   | DM request outstanding, waiting for ack or timeout
//   DONE  | access complete; load data valid for one cycle
//   ERR   | access aborted (misaligned, read+write, or timeout)
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int WAIT_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mem_access_ctrl_if.slave bus,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              stall;
    logic              start;
    logic              start_ok;

    assign start    = bus.i_mem_read | bus.i_mem_write;
    assign start_ok = (bus.i_addr[1:0] == 2'b00) & ~(bus.i_mem_read & bus.i_mem_write);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_d = start_ok ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // Ack takes priority over an expiring wait timer.
                if (bus.i_dm_ack) begin
                    state_d = ST_DONE;
                end else if (wait_q == '0) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Wait timer counts down from TIMEOUT-1; terminal count 0 in REQ without
    // ack is the last permitted request cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                addr_q  <= bus.i_addr;
                wdata_q <= bus.i_wdata;
                we_q    <= bus.i_mem_write;
                wait_q  <= WAIT_TOP;
            end
            if (state_q == ST_REQ && !bus.i_dm_ack && wait_q != '0) begin
                wait_q <= wait_q - 1'b1;
            end
            if (state_q == ST_REQ && bus.i_dm_ack && !we_q) begin
                rdata_q <= bus.i_dm_rdata;
            end
            // Any abort clears the returned load data.
            if (state_d == ST_ERR && state_q != ST_ERR) begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.o_stall       = stall;
    assign bus.o_dm_req      = (state_q == ST_REQ);
    assign bus.o_dm_we       = (state_q == ST_REQ) & we_q;
    assign bus.o_dm_addr     = addr_q;
    assign bus.o_dm_wdata    = wdata_q;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_rdata_valid = (state_q == ST_DONE) & ~we_q;
    assign bus.o_err         = (state_q == ST_ERR);
    assign o_stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus16 ();
    mem_access_ctrl_if bus4 ();

    assign bus16.i_mem_read  = mem_read;
    assign bus16.i_mem_write = mem_write;
    assign bus16.i_addr      = addr;
    assign bus16.i_wdata     = wdata;
    assign bus16.i_dm_ack    = dm_ack;
    assign bus16.i_dm_rdata  = dm_rdata;
    assign bus4.i_mem_read   = mem_read;
    assign bus4.i_mem_write  = mem_write;
    assign bus4.i_addr       = addr;
    assign bus4.i_wdata      = wdata;
    assign bus4.i_dm_ack     = dm_ack;
    assign bus4.i_dm_rdata   = dm_rdata;

    mem_access_ctrl #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus16.slave), .o_stall_cnt(cnt16));
    mem_access_ctrl #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave), .o_stall_cnt(cnt4));

    int n_checks = 0;
    int n_err    = 0;

    // Expected outputs for the current cycle, produced by the transaction model.
    bit          exp_on = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_vld, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    longint      exp_cnt;
    longint      stall_total = 0;
    logic [31:0] rdata_hold  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    task automatic set_exp(input logic st, input logic rq, input logic we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic vld, input logic er, input logic [31:0] rd);
        exp_stall = st; exp_req = rq; exp_we = we; exp_addr = a; exp_wdata = d;
        exp_vld = vld; exp_err = er; exp_rdata = rd;
        exp_cnt = stall_total;          // counter is registered: reflects previous cycles
        if (st) stall_total++;
        exp_on = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_on && rst_n) begin
            chk("stall", bus16.o_stall, exp_stall);
            chk("dm_req", bus16.o_dm_req, exp_req);
            chk("dm_we", bus16.o_dm_we, exp_we);
            if (exp_req) begin
                chk("dm_addr", bus16.o_dm_addr, exp_addr);
                chk("dm_wdata", bus16.o_dm_wdata, exp_wdata);
            end
            chk("rdata_valid", bus16.o_rdata_valid, exp_vld);
            chk("err", bus16.o_err, exp_err);
            chk("rdata", bus16.o_rdata, exp_rdata);
            chk("stall_cnt16", cnt16, sat(exp_cnt, 16));
            chk("stall_cnt4", cnt4, sat(exp_cnt, 4));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
            dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
            set_exp(0, 0, 0, '0, '0, 0, 0, rdata_hold);
        end
    endtask

    // One access: issue cycle, REQ cycles, then DONE/ERR cycle with the
    // instruction still held on the inputs. ack_at = REQ cycle of ack, 0 = never.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input int ack_at, input logic [31:0] rdat);
        bit ok = (a[1:0] == 2'b00) && !(rd && wr);
        int n  = (ack_at == 0) ? 15 : ack_at;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
        set_exp(1, 0, 0, '0, '0, 0, 0, rdata_hold);
        if (!ok) begin
            @(posedge clk); #1;
            dm_ack = 1'($urandom_range(0, 1));
            rdata_hold = '0;
            set_exp(0, 0, 0, '0, '0, 0, 1, '0);
            return;
        end
        for (int j = 1; j <= n; j++) begin
            @(posedge clk); #1;
            dm_ack   = (j == ack_at);
            dm_rdata = (j == ack_at) ? rdat : $urandom;
            set_exp(1, 1, wr, a, d, 0, 0, rdata_hold);
        end
        @(posedge clk); #1;
        dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
        if (ack_at == 0) begin
            rdata_hold = '0;
            set_exp(0, 0, 0, '0, '0, 0, 1, '0);
        end else begin
            if (rd) rdata_hold = rdat;
            set_exp(0, 0, 0, '0, '0, rd, 0, rdata_hold);
        end
    endtask

    initial begin
        rst_n = 0; mem_read = 0; mem_write = 0; addr = '0; wdata = '0;
        dm_ack = 0; dm_rdata = '0;
        #2;
        chk("reset_stall", bus16.o_stall, 0);
        chk("reset_req", bus16.o_dm_req, 0);
        chk("reset_rdata", bus16.o_rdata, 0);
        chk("reset_cnt", cnt16, 0);
        @(posedge clk); #1 rst_n = 1;
        idle(2);

        // Load 0x10, ack on 2nd REQ cycle.
        run_txn(1, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF);
        @(negedge clk);
        chk("pin_load_rdata", bus16.o_rdata, 32'hDEADBEEF);
        chk("pin_load_valid", bus16.o_rdata_valid, 1);
        chk("pin_load_cnt", cnt16, 3);
        idle(1);

        // Store 0x20, ack on 1st REQ cycle.
        run_txn(0, 1, 32'h20, 32'h12345678, 1, 32'h0);
        @(negedge clk);
        chk("pin_store_valid", bus16.o_rdata_valid, 0);
        chk("pin_store_err", bus16.o_err, 0);
        chk("pin_store_cnt", cnt16, 5);

        // Load with no ack: 15 REQ cycles then abort.
        run_txn(1, 0, 32'h44, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("pin_to_err", bus16.o_err, 1);
        chk("pin_to_rdata", bus16.o_rdata, 0);
        chk("pin_to_cnt", cnt16, 21);

        // Misaligned load.
        run_txn(1, 0, 32'h13, 32'h0, 1, 32'h0);
        @(negedge clk);
        chk("pin_mis_err", bus16.o_err, 1);
        chk("pin_mis_cnt", cnt16, 22);

        // Ack on the very last permitted REQ cycle, then read+write both set.
        run_txn(1, 0, 32'h80, 32'h0, 15, 32'hCAFEF00D);
        run_txn(1, 1, 32'h84, 32'h0, 1, 32'h0);
        idle(2);

        // Async reset in the 3rd REQ cycle.
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; addr = 32'h100; dm_ack = 0;
        set_exp(1, 0, 0, '0, '0, 0, 0, rdata_hold);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk); #1;
            dm_ack = 0;
            set_exp(1, 1, 0, 32'h100, wdata, 0, 0, rdata_hold);
        end
        #2;
        exp_on = 0; rst_n = 0; mem_read = 0;
        #1;
        chk("rst_mid_stall", bus16.o_stall, 0);
        chk("rst_mid_req", bus16.o_dm_req, 0);
        chk("rst_mid_cnt", cnt16, 0);
        @(posedge clk); #1 rst_n = 1;
        stall_total = 0; rdata_hold = '0;
        idle(2);

        // Randomized traffic.
        repeat (300) begin
            int sel  = $urandom_range(0, 19);
            int ackv = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 15);
            logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
            if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (sel == 1) run_txn(1, 1, a, $urandom, ackv, $urandom);
            else if (sel < 11) run_txn(1, 0, a, $urandom, ackv, $urandom);
            else run_txn(0, 1, a, $urandom, ackv, $urandom);
            idle($urandom_range(0, 3));
        end

        @(negedge clk);
        chk("pin_cnt4_sat", cnt4, 4'hF);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
